// File: rtl/vga_capture.sv
// Frame grabber: registers a DE-qualified 12-bit video stream and writes each active
// frame into a linear frame buffer, checking line length and line count per frame.
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter int SYNC_POL = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              vid_hsync,
    input  logic              vid_vsync,
    input  logic              vid_de,
    input  logic [11:0]       vid_rgb,
    input  logic              cap_start,
    input  logic              cap_cont,
    input  logic              cap_stop,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              err_size,
    output logic [7:0]        frame_cnt
);

    localparam int CNT_W = 16;
    localparam logic SYNC_LVL = (SYNC_POL != 0);
    localparam logic [CNT_W-1:0] H_CNT = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_CNT = CNT_W'(V_ACTIVE);
    // One extra address bit so the counter can sit one past the last pixel without wrapping.
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE
    } state_t;

    state_t             state_q, state_d;
    logic               cont_q, cont_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               de_q, de_d;
    logic [11:0]        rgb_q, rgb_d;
    logic               vs_d1_q, vs_d1_d;
    logic               de_d1_q, de_d1_d;
    logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]   line_cnt_q, line_cnt_d;
    logic [ADDR_W:0]    addr_cnt_q, addr_cnt_d;
    logic               frame_err_q, frame_err_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [11:0]        wr_data_q, wr_data_d;
    logic               frame_done_q, frame_done_d;
    logic               err_q, err_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;

    logic vs_edge;
    logic de_fall;
    logic hs_active;

    assign vs_edge   = (vs_q == SYNC_LVL) && (vs_d1_q != SYNC_LVL);
    assign de_fall   = de_d1_q && !de_q;
    assign hs_active = (hs_q == SYNC_LVL);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            cont_q       <= 1'b0;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            de_q         <= 1'b0;
            rgb_q        <= '0;
            vs_d1_q      <= 1'b0;
            de_d1_q      <= 1'b0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            addr_cnt_q   <= '0;
            frame_err_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cont_q       <= cont_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            de_q         <= de_d;
            rgb_q        <= rgb_d;
            vs_d1_q      <= vs_d1_d;
            de_d1_q      <= de_d1_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            addr_cnt_q   <= addr_cnt_d;
            frame_err_q  <= frame_err_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cont_d       = cont_q;
        hs_d         = vid_hsync;
        vs_d         = vid_vsync;
        de_d         = vid_de;
        rgb_d        = vid_rgb;
        vs_d1_d      = vs_q;
        de_d1_d      = de_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        addr_cnt_d   = addr_cnt_q;
        frame_err_d  = frame_err_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        err_d        = err_q;
        frame_cnt_d  = frame_cnt_q;

        case (state_q)
            IDLE: begin
                if (cap_start && !cap_stop) begin
                    state_d = ARM;
                    cont_d  = cap_cont;
                    err_d   = 1'b0;
                end
            end

            ARM: begin
                if (cap_stop) begin
                    state_d = IDLE;
                end else if (vs_edge) begin
                    state_d     = CAPTURE;
                    pix_cnt_d   = '0;
                    line_cnt_d  = '0;
                    addr_cnt_d  = '0;
                    wr_addr_d   = '0;
                    frame_err_d = 1'b0;
                end
            end

            CAPTURE: begin
                if (cap_stop) begin
                    state_d = IDLE;
                end else if (vs_edge) begin
                    // The vsync edge closes the frame just captured and opens the next one.
                    if (line_cnt_q == V_CNT && !frame_err_q) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d     = cont_q ? CAPTURE : IDLE;
                    pix_cnt_d   = '0;
                    line_cnt_d  = '0;
                    addr_cnt_d  = '0;
                    wr_addr_d   = '0;
                    frame_err_d = 1'b0;
                end else begin
                    if (de_q) begin
                        if (pix_cnt_q != '1) begin
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end
                        if (hs_active) begin
                            err_d       = 1'b1;
                            frame_err_d = 1'b1;
                        end
                        if (addr_cnt_q > LAST_ADDR) begin
                            err_d       = 1'b1;
                            frame_err_d = 1'b1;
                        end else begin
                            wr_en_d    = 1'b1;
                            wr_addr_d  = addr_cnt_q[ADDR_W-1:0];
                            wr_data_d  = rgb_q;
                            addr_cnt_d = addr_cnt_q + 1'b1;
                        end
                    end
                    if (de_fall) begin
                        if (pix_cnt_q != H_CNT) begin
                            err_d       = 1'b1;
                            frame_err_d = 1'b1;
                        end
                        if (line_cnt_q != '1) begin
                            line_cnt_d = line_cnt_q + 1'b1;
                        end
                        pix_cnt_d = '0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign err_size   = err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a tiny 4x3 frame so whole frames fit in a few cycles.
module tb_vga_capture;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int AW = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          vid_hsync;
    logic          vid_vsync;
    logic          vid_de;
    logic [11:0]   vid_rgb;
    logic          cap_start;
    logic          cap_cont;
    logic          cap_stop;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          busy;
    logic          frame_done;
    logic          err_size;
    logic [7:0]    frame_cnt;

    vga_capture #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .ADDR_W  (AW),
        .SYNC_POL(0)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .vid_hsync (vid_hsync),
        .vid_vsync (vid_vsync),
        .vid_de    (vid_de),
        .vid_rgb   (vid_rgb),
        .cap_start (cap_start),
        .cap_cont  (cap_cont),
        .cap_stop  (cap_stop),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .frame_done(frame_done),
        .err_size  (err_size),
        .frame_cnt (frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    // Write log and frame_done tally, sampled on the falling edge.
    logic [AW-1:0] log_addr [0:255];
    logic [11:0]   log_data [0:255];
    int            wr_total   = 0;
    int            done_total = 0;

    always @(negedge sys_clk) begin
        if (wr_en) begin
            if (wr_total < 256) begin
                log_addr[wr_total] = wr_addr;
                log_data[wr_total] = wr_data;
            end
            wr_total++;
        end
        if (frame_done) begin
            done_total++;
        end
    end

    logic [3:0] tag;
    logic [7:0] pix_idx;
    int         base;
    int         d0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic drive(input logic hs, input logic vs, input logic de, input logic [11:0] rgb);
        vid_hsync = hs;
        vid_vsync = vs;
        vid_de    = de;
        vid_rgb   = rgb;
        @(negedge sys_clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b1, 1'b0, 12'h000);
    endtask

    task automatic send_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b1, 1'b1, {tag, pix_idx});
            pix_idx++;
        end
    endtask

    task automatic line_tail();
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 12'h000);
        idle(1);
    endtask

    task automatic send_line(input int n);
        send_pixels(n);
        line_tail();
    endtask

    task automatic send_vsync();
        drive(1'b1, 1'b0, 1'b0, 12'h000);
        drive(1'b1, 1'b0, 1'b0, 12'h000);
        idle(2);
        pix_idx = '0;
    endtask

    task automatic pulse_start(input logic cont);
        cap_cont  = cont;
        cap_start = 1'b1;
        idle(1);
        cap_start = 1'b0;
    endtask

    task automatic check_log(input int first, input int n, input logic [3:0] t);
        for (int i = 0; i < n; i++) begin
            check("log_addr", 32'(log_addr[first + i]), 32'(i));
            check("log_data", 32'(log_data[first + i]), 32'({t, 8'(i)}));
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_wr_en"},      32'(wr_en),      0);
        check({name, "_wr_addr"},    32'(wr_addr),    0);
        check({name, "_wr_data"},    32'(wr_data),    0);
        check({name, "_busy"},       32'(busy),       0);
        check({name, "_frame_done"}, 32'(frame_done), 0);
        check({name, "_err_size"},   32'(err_size),   0);
        check({name, "_frame_cnt"},  32'(frame_cnt),  0);
    endtask

    initial begin
        sys_rst   = 1'b1;
        cap_start = 1'b0;
        cap_cont  = 1'b0;
        cap_stop  = 1'b0;
        tag       = 4'h0;
        pix_idx   = '0;
        vid_hsync = 1'b1;
        vid_vsync = 1'b1;
        vid_de    = 1'b1;
        vid_rgb   = 12'hABC;
        repeat (3) @(negedge sys_clk);
        check_all_zero("reset");
        sys_rst = 1'b0;
        idle(2);

        // Single frame; a second start in ARM with cap_cont=1 must not re-latch continuous mode.
        $display("[TB] single frame");
        base = wr_total;
        d0   = done_total;
        tag  = 4'h1;
        pulse_start(1'b0);
        check("arm_busy", 32'(busy), 1);
        cap_cont  = 1'b1;
        cap_start = 1'b1;
        idle(1);
        cap_start = 1'b0;
        cap_cont  = 1'b0;
        send_vsync();
        send_pixels(1);
        check("lat_wr_en_early", 32'(wr_en), 0);
        send_pixels(1);
        check("lat_wr_en", 32'(wr_en), 1);
        check("lat_wr_data", 32'(wr_data), 32'h100);
        check("lat_wr_addr", 32'(wr_addr), 0);
        send_pixels(2);
        line_tail();
        send_line(H);
        send_line(H);
        send_vsync();
        idle(2);
        check("single_writes", 32'(wr_total - base), 12);
        check_log(base, 12, 4'h1);
        check("single_done", 32'(done_total - d0), 1);
        check("single_frame_cnt", 32'(frame_cnt), 1);
        check("single_busy", 32'(busy), 0);
        check("single_err", 32'(err_size), 0);

        // Continuous: three good frames, address restarts at 0 each frame.
        $display("[TB] continuous");
        base = wr_total;
        d0   = done_total;
        pulse_start(1'b1);
        tag = 4'h2;
        send_vsync();
        repeat (V) send_line(H);
        tag = 4'h3;
        send_vsync();
        repeat (V) send_line(H);
        tag = 4'h4;
        send_vsync();
        repeat (V) send_line(H);
        send_vsync();
        idle(2);
        check("cont_done", 32'(done_total - d0), 3);
        check("cont_frame_cnt", 32'(frame_cnt), 4);
        check("cont_busy", 32'(busy), 1);
        check("cont_err", 32'(err_size), 0);
        check("cont_writes", 32'(wr_total - base), 36);
        check_log(base, 12, 4'h2);
        check_log(base + 12, 12, 4'h3);
        check_log(base + 24, 12, 4'h4);
        cap_stop = 1'b1;
        idle(1);
        cap_stop = 1'b0;
        check("cont_stop_busy", 32'(busy), 0);

        // Short second line.
        $display("[TB] short line");
        base = wr_total;
        d0   = done_total;
        tag  = 4'h5;
        pulse_start(1'b0);
        send_vsync();
        send_line(H);
        send_line(H - 1);
        send_line(H);
        send_vsync();
        idle(2);
        check("short_err", 32'(err_size), 1);
        check("short_done", 32'(done_total - d0), 0);
        check("short_frame_cnt", 32'(frame_cnt), 4);
        check("short_busy", 32'(busy), 0);
        check("short_writes", 32'(wr_total - base), 11);
        check_log(base, 11, 4'h5);

        // One extra line: writes beyond the last address are dropped.
        $display("[TB] overlong frame");
        base = wr_total;
        d0   = done_total;
        tag  = 4'h6;
        pulse_start(1'b0);
        check("start_clears_err", 32'(err_size), 0);
        send_vsync();
        repeat (V + 1) send_line(H);
        send_vsync();
        idle(2);
        check("over_writes", 32'(wr_total - base), 12);
        check("over_last_addr", 32'(log_addr[base + 11]), 11);
        check("over_err", 32'(err_size), 1);
        check("over_done", 32'(done_total - d0), 0);
        check("over_frame_cnt", 32'(frame_cnt), 4);

        // DE while hsync is asserted.
        $display("[TB] de during hsync");
        base = wr_total;
        d0   = done_total;
        tag  = 4'h7;
        pulse_start(1'b0);
        check("hs_err_cleared", 32'(err_size), 0);
        send_vsync();
        send_line(H);
        drive(1'b0, 1'b1, 1'b1, {tag, pix_idx});
        pix_idx++;
        send_pixels(H - 1);
        line_tail();
        send_line(H);
        send_vsync();
        idle(2);
        check("hs_err", 32'(err_size), 1);
        check("hs_done", 32'(done_total - d0), 0);
        check("hs_frame_cnt", 32'(frame_cnt), 4);
        check("hs_writes", 32'(wr_total - base), 12);

        // Stop in the middle of a line.
        $display("[TB] mid-frame stop");
        base = wr_total;
        d0   = done_total;
        tag  = 4'h8;
        pulse_start(1'b1);
        send_vsync();
        send_line(H);
        send_pixels(2);
        cap_stop = 1'b1;
        send_pixels(1);
        cap_stop = 1'b0;
        check("stop_wr_en", 32'(wr_en), 0);
        check("stop_busy", 32'(busy), 0);
        send_pixels(1);
        line_tail();
        send_line(H);
        send_vsync();
        idle(2);
        check("stop_writes", 32'(wr_total - base), 5);
        check("stop_frame_cnt", 32'(frame_cnt), 4);
        check("stop_done", 32'(done_total - d0), 0);
        check("stop_busy_after", 32'(busy), 0);

        // Reset in the middle of a line.
        $display("[TB] reset during capture");
        base = wr_total;
        d0   = done_total;
        tag  = 4'h9;
        pulse_start(1'b1);
        send_vsync();
        send_line(H);
        send_pixels(2);
        sys_rst = 1'b1;
        send_pixels(1);
        check_all_zero("midrst");
        sys_rst = 1'b0;
        send_pixels(1);
        line_tail();
        send_line(H);
        send_vsync();
        idle(2);
        check("rst_writes", 32'(wr_total - base), 5);
        check("rst_done", 32'(done_total - d0), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
